cic_stream_ctrl: RTL
====================

# cic_stream_ctrl

Sequencing controller for the two-stage CIC decimation datapath. It owns the CIC's reset and sample-enable. It holds the filter cleared while idle and discards outputs until the comb delay lines are settled. It then decimates the CIC output stream by DECIM and presents each kept sample on a valid/ready output port with overrun detection. It sits between the ADC sample source and the downstream consumer, directly driving the CIC's i_reset, i_filter_en and i_cic_data.

## Interface
- IN_W, 12: input sample width; matches CIC input.
- OUT_W, 20: CIC output and o_out_data width.
- DECIM, 16: decimation ratio, ≥2.
- SETTLE_EN, 36: enables discarded after start (2×16 comb depth + 4 pipeline enables).
- CNT_W, 16: width of o_sample_cnt.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle pulse; begins a run from IDLE; ignored elsewhere.
- i_stop  in  1  one-cycle pulse; aborts SETTLE/RUN; ignored in IDLE.
- i_in_valid  in  1  input sample present.
- i_in_data  in  IN_W  signed input sample.
- o_in_ready  out  1  sample accepted this cycle when valid && ready.
- o_filter_reset_n  out  1  registered; drives CIC i_reset.
- o_filter_en  out  1  drives CIC i_filter_en.
- o_filter_data  out  IN_W  drives CIC i_cic_data.
- i_filter_data  in  OUT_W  CIC o_cic_data.
- o_out_valid  out  1  decimated sample held.
- i_out_ready  in  1  consumer accepts.
- o_out_data  out  OUT_W  decimated sample.
- o_busy  out  1  state != IDLE.
- o_overrun  out  1  sticky; a kept sample was dropped.
- o_sample_cnt  out  CNT_W  count of samples transferred out; wraps.

## Operation
- States: IDLE, SETTLE, RUN; registered state.
- IDLE: o_filter_reset_n=0 (CIC held clear), o_in_ready=0. i_start → SETTLE. On the same edge, clear o_overrun, o_sample_cnt, settle_cnt and decim_cnt.
- SETTLE: o_filter_reset_n=1, o_in_ready=1. Each enable increments settle_cnt. The enable that brings settle_cnt to SETTLE_EN → RUN with decim_cnt=0.
- RUN: o_in_ready=1. Each enable increments decim_cnt modulo DECIM. The enable at decim_cnt==DECIM-1 sets cap_pend for one cycle.
- i_stop in SETTLE or RUN → IDLE next edge; takes priority over the settle/decim transitions of that cycle. o_filter_reset_n goes low on that edge.
- o_filter_en = i_in_valid && o_in_ready (combinational). o_filter_data = i_in_data (pass-through).
- Capture: when cap_pend=1, i_filter_data holds the CIC output of the marking enable.
  - If the holding register is free, or is emptying this cycle (o_out_valid && i_out_ready), load o_out_data and set o_out_valid=1.
  - Otherwise drop the sample, keep the old data, and set o_overrun=1.
- cap_pend is independent of state: a capture set by the last RUN enable completes even if i_stop arrives on that cycle.
- Output transfer on o_out_valid && i_out_ready: o_sample_cnt+1 (wraps at 2^CNT_W). o_out_valid clears unless reloaded the same cycle.
- A held o_out_valid survives i_stop and persists in IDLE until accepted. It is cleared only by i_reset.
- Only i_reset or the i_start edge clears o_overrun.

## Timing
- Reset values: state=IDLE, o_filter_reset_n=0, o_in_ready=0, o_filter_en=0, o_out_valid=0, o_out_data=0, o_overrun=0, o_sample_cnt=0, o_busy=0, cap_pend=0.
- Start: pulse at cycle t → o_busy and o_filter_reset_n high from t+1; first acceptable sample at t+1.
- CIC path latency is 4 enables. The controller adds 1 cycle from the marking enable edge to o_out_valid.
- With continuous input, o_out_valid rises one cycle after the (SETTLE_EN+DECIM)-th accepted sample. Subsequent outputs follow every DECIM accepted samples.
- Input gaps (i_in_valid=0) freeze all counters; no enable is issued.
- o_out_data is stable while o_out_valid=1 and i_out_ready=0.

## Test plan
- Reset mid-RUN: assert i_reset with o_out_valid=1 → all outputs at reset values immediately (asynchronous); o_filter_reset_n=0.
- DC step: start, continuous input 1, DECIM=16 → first o_out_valid one cycle after the 52nd accepted sample, data 256. Every 16 samples thereafter: 256, o_sample_cnt increments, o_overrun=0.
- Input gaps: same DC stream with i_in_valid toggling 1/0 → identical output values; first valid one cycle after the 52nd accepted sample.
- Backpressure: i_out_ready=0 across two captures → first sample held unchanged, o_overrun=1 at the second capture cycle. Then ready=1 → one transfer, o_sample_cnt=1.
- Simultaneous transfer and capture: ready=1 on the cap_pend cycle with valid=1 → new data loaded, o_out_valid stays 1, no overrun.
- Stop/restart: i_stop during SETTLE → IDLE next cycle, o_filter_reset_n=0, no output. i_start → o_overrun and o_sample_cnt clear; full settle repeats (52 samples to first output). i_start while busy → ignored.

Source files
------------

// File: rtl/cic_stream_ctrl.sv
// cic_stream_ctrl: sequencing controller for the two-stage CIC decimation path.
// Holds the CIC cleared while idle, discards outputs until the comb delay
// lines have settled, then keeps every DECIM-th CIC output and presents it on
// a valid/ready port with sticky overrun detection.
module cic_stream_ctrl #(
   parameter int IN_W      = 12,
   parameter int OUT_W     = 20,
   parameter int DECIM     = 16,
   parameter int SETTLE_EN = 36,
   parameter int CNT_W     = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic             i_in_valid,
   input  logic [IN_W-1:0]  i_in_data,
   output logic             o_in_ready,
   output logic             o_filter_reset_n,
   output logic             o_filter_en,
   output logic [IN_W-1:0]  o_filter_data,
   input  logic [OUT_W-1:0] i_filter_data,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [OUT_W-1:0] o_out_data,
   output logic             o_busy,
   output logic             o_overrun,
   output logic [CNT_W-1:0] o_sample_cnt
);

   localparam int SC_W = $clog2(SETTLE_EN + 1);
   localparam int DC_W = (DECIM > 2) ? $clog2(DECIM) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_RUN
   } state_t;

   state_t           state_q;
   logic             filt_rst_n_q;
   logic             in_ready_q;
   logic [SC_W-1:0]  settle_cnt_q;
   logic [DC_W-1:0]  decim_cnt_q;

   logic             cap_pend_q,   cap_pend_d;
   logic             out_valid_q,  out_valid_d;
   logic [OUT_W-1:0] out_data_q,   out_data_d;
   logic             overrun_q,    overrun_d;
   logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;

   logic             filter_en;
   logic             start_edge;
   logic             xfer;

   assign filter_en  = i_in_valid & in_ready_q;
   assign start_edge = (state_q == ST_IDLE) & i_start;
   assign xfer       = out_valid_q & i_out_ready;

   // Run-state sequencing with registered CIC reset and input-ready outputs
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q      <= ST_IDLE;
         filt_rst_n_q <= 1'b0;
         in_ready_q   <= 1'b0;
         settle_cnt_q <= '0;
         decim_cnt_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  state_q      <= ST_SETTLE;
                  filt_rst_n_q <= 1'b1;
                  in_ready_q   <= 1'b1;
                  settle_cnt_q <= '0;
                  decim_cnt_q  <= '0;
               end
            end
            ST_SETTLE: begin
               if (i_stop) begin
                  state_q      <= ST_IDLE;
                  filt_rst_n_q <= 1'b0;
                  in_ready_q   <= 1'b0;
               end else if (filter_en) begin
                  settle_cnt_q <= settle_cnt_q + SC_W'(1);
                  if (settle_cnt_q == SC_W'(SETTLE_EN - 1)) begin
                     state_q     <= ST_RUN;
                     decim_cnt_q <= '0;
                  end
               end
            end
            ST_RUN: begin
               if (i_stop) begin
                  state_q      <= ST_IDLE;
                  filt_rst_n_q <= 1'b0;
                  in_ready_q   <= 1'b0;
               end else if (filter_en) begin
                  if (decim_cnt_q == DC_W'(DECIM - 1)) begin
                     decim_cnt_q <= '0;
                  end else begin
                     decim_cnt_q <= decim_cnt_q + DC_W'(1);
                  end
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               filt_rst_n_q <= 1'b0;
               in_ready_q   <= 1'b0;
            end
         endcase
      end
   end

   // Capture, output hand-off, overrun and transfer count next-state
   always_comb begin
      // The marking enable schedules a capture even when i_stop lands on the
      // same cycle, so the last kept sample of a run is never lost.
      cap_pend_d   = filter_en & (state_q == ST_RUN) &
                     (decim_cnt_q == DC_W'(DECIM - 1));
      out_valid_d  = out_valid_q & ~xfer;
      out_data_d   = out_data_q;
      overrun_d    = overrun_q;
      sample_cnt_d = xfer ? sample_cnt_q + CNT_W'(1) : sample_cnt_q;
      if (cap_pend_q) begin
         if (!out_valid_q || xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = i_filter_data;
         end else begin
            overrun_d = 1'b1;
         end
      end
      if (start_edge) begin
         overrun_d    = 1'b0;
         sample_cnt_d = '0;
      end
   end

   // Output holding register and status state
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         cap_pend_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         overrun_q    <= 1'b0;
         sample_cnt_q <= '0;
      end else begin
         cap_pend_q   <= cap_pend_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         overrun_q    <= overrun_d;
         sample_cnt_q <= sample_cnt_d;
      end
   end

   assign o_in_ready       = in_ready_q;
   assign o_filter_reset_n = filt_rst_n_q;
   assign o_filter_en      = filter_en;
   assign o_filter_data    = i_in_data;
   assign o_out_valid      = out_valid_q;
   assign o_out_data       = out_data_q;
   assign o_busy           = (state_q != ST_IDLE);
   assign o_overrun        = overrun_q;
   assign o_sample_cnt     = sample_cnt_q;

endmodule
